ser_load_ctrl: RTL and testbench



---
 rtl/ser_load_ctrl_pkg.sv | 12 +
 rtl/ser_load_ctrl_cntr_nb_sclr.sv | 23 ++
 rtl/ser_load_ctrl.sv | 86 ++++++++
 tb/tb_ser_load_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/ser_load_ctrl_pkg.sv
// Shared definitions for the serial-to-parallel loader: FSM encodings and default width.
package ser_load_ctrl_pkg;

   localparam int unsigned SerWidthDefault = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StLoad  = 2'd2
   } ser_state_e;

endpackage

// File: rtl/ser_load_ctrl_cntr_nb_sclr.sv
// Parameterised up-counter with synchronous active-high clear (clear beats enable).
module cntr_nb_sclr #(
   parameter int unsigned Width = 3
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/ser_load_ctrl.sv
// Assembles an n-bit word from an MSB-first serial stream and strobes ld for one cycle
// when the completed word is presented on data_out_o.
module ser_load_ctrl
   import ser_load_ctrl_pkg::*;
#(
   parameter int unsigned n = SerWidthDefault
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         start_i,
   input  logic         ser_in_i,
   input  logic         ser_en_i,
   output logic [n-1:0] data_out_o,
   output logic         ld_o,
   output logic         busy_o
);

   localparam int unsigned CntW = $clog2(n);
   localparam logic [CntW-1:0] LastCnt = CntW'(n - 1);

   ser_state_e      state_q;
   logic [n-1:0]    sreg_q;
   logic [n-1:0]    data_q;
   logic            ld_q;
   logic            busy_q;
   logic [CntW-1:0] cnt;
   logic            cnt_clr;
   logic            cnt_en;

   assign cnt_clr = clr_i | ((state_q == StIdle) & start_i);
   // Hold at n-1 on the final bit so the counter never wraps.
   assign cnt_en  = (state_q == StShift) & ser_en_i & (cnt != LastCnt);

   cntr_nb_sclr #(
      .Width (CntW)
   ) u_cntr (
      .clk_i   (clk_i),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (cnt)
   );

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q <= StIdle;
         sreg_q  <= '0;
         data_q  <= '0;
         ld_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ld_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  sreg_q  <= '0;
                  state_q <= StShift;
                  busy_q  <= 1'b1;
               end
            end
            StShift: begin
               if (ser_en_i) begin
                  sreg_q <= {sreg_q[n-2:0], ser_in_i};
                  if (cnt == LastCnt) begin
                     data_q  <= {sreg_q[n-2:0], ser_in_i};
                     state_q <= StLoad;
                     ld_q    <= 1'b1;
                  end
               end
            end
            StLoad: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign data_out_o = data_q;
   assign ld_o       = ld_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_ser_load_ctrl.sv
// Directed self-checking bench for ser_load_ctrl (n=8) with a stand-in downstream register.
module tb_ser_load_ctrl;

   logic       clk_i;
   logic       clr_i;
   logic       start_i;
   logic       ser_in_i;
   logic       ser_en_i;
   logic [7:0] data_out_o;
   logic       ld_o;
   logic       busy_o;
   logic [7:0] reg_q;

   int checks = 0;
   int errors = 0;

   ser_load_ctrl #(
      .n (8)
   ) dut (
      .clk_i      (clk_i),
      .clr_i      (clr_i),
      .start_i    (start_i),
      .ser_in_i   (ser_in_i),
      .ser_en_i   (ser_en_i),
      .data_out_o (data_out_o),
      .ld_o       (ld_o),
      .busy_o     (busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Downstream loadable register: clr has priority over ld.
   always_ff @(posedge clk_i) begin
      if (clr_i) reg_q <= '0;
      else if (ld_o) reg_q <= data_out_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Runs ncyc cycles starting with the start pulse in cycle 0; checks outputs every cycle.
   task automatic capture(input string tag, input logic [7:0] w, input logic [31:0] stall_m,
                          input logic [31:0] start_m, input int ld_cyc, input logic [7:0] prev,
                          input int clr_cyc, input int ncyc);
      int bi;
      bit cleared;
      bi = 0;
      cleared = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         clr_i    = (c == clr_cyc);
         start_i  = (c == 0) || start_m[c];
         ser_in_i = 1'($urandom);
         ser_en_i = 1'b0;
         if (!cleared && c >= 1 && bi < 8) begin
            ser_en_i = !stall_m[c];
            ser_in_i = w[7-bi];
            if (ser_en_i && !clr_i) bi++;
         end
         if (cleared) start_i = 1'b0;
         chk({tag, "_ld"},   32'(ld_o),   32'(!cleared && c == ld_cyc));
         chk({tag, "_busy"}, 32'(busy_o), 32'(!cleared && c >= 1 && c <= ld_cyc));
         chk({tag, "_data"}, 32'(data_out_o),
             cleared ? 32'h0 : (c >= ld_cyc ? 32'(w) : 32'(prev)));
         if (c == clr_cyc) cleared = 1'b1;
         step();
      end
      clr_i    = 1'b0;
      start_i  = 1'b0;
      ser_en_i = 1'b0;
   endtask

   initial begin
      clr_i    = 1'b1;
      start_i  = 1'b0;
      ser_in_i = 1'b0;
      ser_en_i = 1'b0;

      // Reset with random inputs.
      for (int i = 0; i < 3; i++) begin
         clr_i    = 1'b1;
         start_i  = 1'($urandom);
         ser_in_i = 1'($urandom);
         ser_en_i = 1'($urandom);
         step();
         chk("rst_data", 32'(data_out_o), 32'h0);
         chk("rst_ld",   32'(ld_o),       32'h0);
         chk("rst_busy", 32'(busy_o),     32'h0);
      end
      clr_i    = 1'b0;
      start_i  = 1'b0;
      ser_en_i = 1'b0;
      step();
      chk("idle_busy", 32'(busy_o), 32'h0);

      capture("basic", 8'hB2, 32'h0, 32'h0, 9, 8'h00, -1, 10);
      capture("stall", 8'hB2, 32'h0000_00A4, 32'h0, 12, 8'hB2, -1, 13);

      capture("ign", 8'h5A, 32'h0, 32'h0000_0210, 9, 8'hB2, -1, 10);
      chk("ign_idle", 32'(busy_o), 32'h0);
      capture("restart", 8'hC3, 32'h0, 32'h0, 9, 8'h5A, -1, 10);

      capture("pre3c", 8'h3C, 32'h0, 32'h0, 9, 8'hC3, -1, 10);
      capture("midclr", 8'hA5, 32'h0, 32'h0, 20, 8'h3C, 5, 8);
      capture("ff", 8'hFF, 32'h0, 32'h0, 9, 8'h00, -1, 10);

      capture("b2b1", 8'h01, 32'h0, 32'h0, 9, 8'hFF, -1, 10);
      chk("reg_01", 32'(reg_q), 32'h01);
      capture("b2b2", 8'h80, 32'h0, 32'h0, 9, 8'h01, -1, 10);
      chk("reg_80", 32'(reg_q), 32'h80);

      // clr during LOAD: ld still visible, then both sides clear.
      capture("ldclr", 8'h69, 32'h0, 32'h0, 9, 8'h80, 9, 11);
      chk("ldclr_reg", 32'(reg_q), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
